// File: rtl/arm_muldiv_pkg.sv
// Shared types and flag helpers for the arm_muldiv iterative multiply/divide unit.
package arm_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_UDIV  = 2'b10,
    OP_RSVD  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } muldiv_state_t;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAG_N  = 3;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_C  = 1;
  localparam int unsigned FLAG_V  = 0;

  // Pack N and Z into an NZCV nibble; this unit never produces carry or overflow.
  function automatic logic [FLAGS_W-1:0] nz_flags(input logic n, input logic z);
    logic [FLAGS_W-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = 1'b0;
    f[FLAG_V] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/arm_muldiv_fsm.sv
// Sequencer for arm_muldiv: state register, step counter, busy/done and fast-path decode.
// ARM_MULDIV_DIV_EN selects whether UDIV with a nonzero divisor runs the iterative path.
module muldiv_fsm
  import arm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       b_zero,
  output logic       accept_c,
  output logic       fast_c,
  output logic       step_c,
  output logic       last_c,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d;
  logic             fast_dec;
  logic             at_last;

  // Operations that complete in one cycle without entering RUN.
`ifdef ARM_MULDIV_DIV_EN
  assign fast_dec = (op == OP_RSVD) || ((op == OP_UDIV) && b_zero);
`else
  assign fast_dec = (op == OP_RSVD) || (op == OP_UDIV);
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

  assign at_last = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state; DONE accepts a new start just like IDLE for back-to-back issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = fast_dec ? S_DONE : S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (at_last) state_d = S_DONE;
        else         cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    fast_c   = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    accept_c = start && (state_q != S_RUN);
    fast_c   = accept_c && fast_dec;
    step_c   = (state_q == S_RUN);
    last_c   = step_c && at_last;
    busy_d   = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
  end

endmodule

// File: rtl/arm_muldiv.sv
// Iterative MUL/UMULL/UDIV unit with start/busy/done handshake and registered NZCV flags.
// Define ARM_MULDIV_DIV_EN to build the restoring divider; otherwise UDIV acts as reserved.
module arm_muldiv
  import arm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result_lo,
  output logic [WIDTH-1:0]   result_hi,
  output logic [FLAGS_W-1:0] flags,
  output logic               div_by_zero
);

  localparam int unsigned W1 = WIDTH + 1;

  muldiv_op_t           op_in, op_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     res_lo_c, res_hi_c;
  logic [FLAGS_W-1:0]   flags_c;
  logic                 accept_c, fast_c, step_c, last_c;
  logic                 b_zero;

`ifdef ARM_MULDIV_DIV_EN
  logic [WIDTH:0]       rem_q, rem_d, shifted;
  logic                 q_bit;
`endif

  assign op_in  = muldiv_op_t'(op);
  assign b_zero = (b == '0);

  muldiv_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .b_zero   (b_zero),
    .accept_c (accept_c),
    .fast_c   (fast_c),
    .step_c   (step_c),
    .last_c   (last_c),
    .busy     (busy),
    .done     (done)
  );

  // One iteration: shift-add multiply, or a restoring-divide step when dividing.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ARM_MULDIV_DIV_EN
    shifted = W1'({rem_q, acc_q[WIDTH-1]});
    rem_d   = shifted;
    q_bit   = 1'b0;
    if (shifted >= {1'b0, opnd_q}) begin
      rem_d = shifted - {1'b0, opnd_q};
      q_bit = 1'b1;
    end
    if (op_q == OP_UDIV) acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
`endif
  end

  // Final result and flags as they will be after the last step.
  always_comb begin
    res_lo_c = acc_d[WIDTH-1:0];
    res_hi_c = '0;
    flags_c  = nz_flags(res_lo_c[WIDTH-1], res_lo_c == '0);
    case (op_q)
      OP_UMULL: begin
        res_hi_c = acc_d[2*WIDTH-1:WIDTH];
        flags_c  = nz_flags(res_hi_c[WIDTH-1], acc_d == '0);
      end
`ifdef ARM_MULDIV_DIV_EN
      OP_UDIV: begin
        res_hi_c = rem_d[WIDTH-1:0];
        flags_c  = nz_flags(res_lo_c[WIDTH-1], (res_lo_c == '0) && (res_hi_c == '0));
      end
`endif
      default: ;
    endcase
  end

  // Multiplicand/divisor share opnd_q; the accumulator low half holds multiplier or dividend.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_MUL;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
`ifdef ARM_MULDIV_DIV_EN
      rem_q       <= '0;
      div_by_zero <= 1'b0;
`endif
    end else if (accept_c) begin
      op_q   <= op_in;
      opnd_q <= (op_in == OP_UDIV) ? b : a;
      acc_q  <= {{WIDTH{1'b0}}, ((op_in == OP_UDIV) ? a : b)};
`ifdef ARM_MULDIV_DIV_EN
      rem_q       <= '0;
      div_by_zero <= 1'b0;
`endif
      if (fast_c) begin
`ifdef ARM_MULDIV_DIV_EN
        if (op_in == OP_UDIV) begin
          result_lo   <= '1;
          result_hi   <= a;
          flags       <= nz_flags(1'b1, 1'b0);
          div_by_zero <= 1'b1;
        end else
`endif
        begin
          result_lo <= '0;
          result_hi <= '0;
          flags     <= nz_flags(1'b0, 1'b1);
        end
      end
    end else if (step_c) begin
      acc_q <= acc_d;
`ifdef ARM_MULDIV_DIV_EN
      rem_q <= rem_d;
`endif
      if (last_c) begin
        result_lo <= res_lo_c;
        result_hi <= res_hi_c;
        flags     <= flags_c;
      end
    end
  end

`ifndef ARM_MULDIV_DIV_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_arm_muldiv.sv
// Directed scoreboard bench for arm_muldiv at WIDTH=32 plus a WIDTH=8 instance.
module tb_arm_muldiv;

  localparam int unsigned W = 32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy, done, dbz;
  logic [31:0] lo, hi;
  logic [3:0]  fl;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        busy8, done8, dbz8;
  logic [3:0]  fl8;

  typedef struct {
    string       tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  fl;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  arm_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .result_lo(lo), .result_hi(hi), .flags(fl),
    .div_by_zero(dbz)
  );

  arm_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8), .flags(fl8),
    .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [1:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    logic        n, z;
    p     = {32'h0, x} * {32'h0, y};
    e.tag = tag;
    e.lo  = '0;
    e.hi  = '0;
    e.dbz = 1'b0;
    e.lat = W + 1;
    case (o)
      2'b00: e.lo = p[31:0];
      2'b01: begin e.lo = p[31:0]; e.hi = p[63:32]; end
      2'b10: begin
`ifdef ARM_MULDIV_DIV_EN
        if (y == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1'b1; e.lat = 1;
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
`else
        e.lat = 1;
`endif
      end
      default: e.lat = 1;
    endcase
    n    = (o == 2'b01) ? e.hi[31] : e.lo[31];
    z    = (e.lo == 0) && (e.hi == 0);
    e.fl = {n, z, 2'b00};
    return e;
  endfunction

  task automatic drive(input string tag, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    op_i  = o;
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    sb.push_back(model(tag, o, x, y));
  endtask

  // Wait for done; start is dropped at cycle 'hold', and inputs are scrambled mid-run when held.
  task automatic wait_done(input int hold);
    exp_t e;
    int   cyc;
    logic got;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e   = sb.pop_front();
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) start = 1'b0;
      if (hold > 1 && cyc == 5) begin
        a_i  = ~a_i;
        b_i  = b_i + 32'd3;
        op_i = 2'b01;
      end
      if (cyc == 1) check({e.tag, "_busy1"}, 64'(busy), 64'(e.lat > 1));
      got = done;
    end
    if (!got) begin
      check({e.tag, "_timeout"}, 64'(cyc), 64'(e.lat));
    end else begin
      check({e.tag, "_lat"},  64'(cyc),  64'(e.lat));
      check({e.tag, "_lo"},   64'(lo),   64'(e.lo));
      check({e.tag, "_hi"},   64'(hi),   64'(e.hi));
      check({e.tag, "_fl"},   64'(fl),   64'(e.fl));
      check({e.tag, "_dbz"},  64'(dbz),  64'(e.dbz));
      check({e.tag, "_busy"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check(tag, 64'(cnt), 64'd0);
  endtask

  task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] elo, input logic [7:0] ehi,
                      input logic [3:0] efl);
    int   cyc;
    logic got;
    op8    = o;
    a8     = x;
    b8     = y;
    start8 = 1'b1;
    cyc    = 0;
    got    = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start8 = 1'b0;
      got = done8;
    end
    check({tag, "_lat"},  64'(cyc),   64'd9);
    check({tag, "_lo"},   64'(lo8),   64'(elo));
    check({tag, "_hi"},   64'(hi8),   64'(ehi));
    check({tag, "_fl"},   64'(fl8),   64'(efl));
    check({tag, "_dbz"},  64'(dbz8),  64'd0);
    check({tag, "_busy"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    int cnt;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    clk    = 1'b0;
    reset  = 1'b0;
    start  = 1'b0;
    op_i   = 2'b00;
    a_i    = '0;
    b_i    = '0;
    start8 = 1'b0;
    op8    = 2'b00;
    a8     = '0;
    b8     = '0;
    n_cmp  = 0;
    n_bad  = 0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_fl",   64'(fl),   64'd0);
    check("rst_dbz",  64'(dbz),  64'd0);
    reset = 1'b1;
    @(negedge clk);

    drive("mul7x6", 2'b00, 32'd7, 32'd6);                       wait_done(1);
    drive("umull_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    wait_done(1);
    drive("udiv100_7", 2'b10, 32'd100, 32'd7);                  wait_done(1);
    drive("udiv5_0", 2'b10, 32'd5, 32'd0);                      wait_done(1);
    drive("rsvd", 2'b11, 32'h1234, 32'h5678);                   wait_done(1);
    quiet("idle_quiet", 3);

    drive("hold_mul", 2'b00, 32'd1234, 32'd5678);               wait_done(20);
    quiet("hold_single_done", 40);

    drive("b2b_first", 2'b00, 32'd9, 32'd9);                    wait_done(1);
    drive("b2b_second", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);   wait_done(1);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 2));
      rx = $urandom;
      ry = (i == 5) ? 32'($urandom_range(1, 20)) : $urandom;
      drive($sformatf("rnd%0d", i), ro, rx, ry);
      wait_done(1);
    end
    @(negedge clk);

    op_i  = 2'b00;
    a_i   = 32'hDEAD;
    b_i   = 32'hBEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_lo",   64'(lo),   64'd0);
    check("abort_hi",   64'(hi),   64'd0);
    check("abort_fl",   64'(fl),   64'd0);
    check("abort_dbz",  64'(dbz),  64'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done_rst", 64'(cnt), 64'd0);
    reset = 1'b1;
    quiet("abort_no_done", 40);
    drive("mul3x3", 2'b00, 32'd3, 32'd3);                       wait_done(1);
    @(negedge clk);

    run8("w8_mul0", 2'b00, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0100);
    @(negedge clk);
    run8("w8_umull", 2'b01, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
